// File: rtl/debounce_event_if.sv
// MMIO slot bus for the debouncer: select/strobes/address/data in, combinational read data out.
interface debounce_event_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/debounce_event_core.sv
// Multi-channel debouncer: 2-FF sync, shared sample prescaler, per-channel stability
// counters, W1C rise/fall pending registers and a registered maskable irq.

module debounce_event_lane #(
    parameter int THRESH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_sync,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = $clog2(THRESH);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_diff;
    logic          w_flip;

    assign w_diff  = i_sync != r_level;
    assign w_flip  = i_tick && w_diff && (r_cnt == CW'(THRESH - 1));
    assign o_level = r_level;
    assign o_rise  = w_flip && !r_level;
    assign o_fall  = w_flip && r_level;

    // Any sample agreeing with the current level restarts the stability run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_tick) begin
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

module debounce_event_core #(
    parameter int          W       = 8,
    parameter int          PW      = 24,
    parameter logic [31:0] DEF_PRD = 32'd999_999,
    parameter int          THRESH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    debounce_event_if.slave        bus,
    input  logic [W-1:0]           din,
    output logic                   irq
);
    logic [W-1:0]  r_sync1;
    logic [W-1:0]  r_sync2;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] r_period;
    logic [W-1:0]  r_rise_pend;
    logic [W-1:0]  r_fall_pend;
    logic [W-1:0]  r_rise_en;
    logic [W-1:0]  r_fall_en;
    logic          r_irq;

    logic [W-1:0]  w_level;
    logic [W-1:0]  w_rise;
    logic [W-1:0]  w_fall;
    logic          w_wr;
    logic [2:0]    w_sel;
    logic          w_wr_prd;
    logic          w_tick;
    logic [W-1:0]  w_clr_rise;
    logic [W-1:0]  w_clr_fall;
    logic [31:0]   w_rd;
    logic          w_unused;

    assign w_wr     = bus.cs && bus.write;
    assign w_sel    = bus.addr[2:0];
    assign w_wr_prd = w_wr && (w_sel == 3'd6);
    // A period write restarts the sample interval, so it never ticks in that cycle.
    assign w_tick   = (r_presc == r_period) && !w_wr_prd;

    assign w_clr_rise = (w_wr && w_sel == 3'd2) ? bus.wr_data[W-1:0] : '0;
    assign w_clr_fall = (w_wr && w_sel == 3'd3) ? bus.wr_data[W-1:0] : '0;

    assign w_unused = &{1'b0, bus.read, bus.addr[4:3], bus.wr_data};

    for (genvar i = 0; i < W; i++) begin : g_lane
        debounce_event_lane #(.THRESH(THRESH)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_tick  (w_tick),
            .i_sync  (r_sync2[i]),
            .o_level (w_level[i]),
            .o_rise  (w_rise[i]),
            .o_fall  (w_fall[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_presc     <= '0;
            r_period    <= PW'(DEF_PRD);
            r_rise_pend <= '0;
            r_fall_pend <= '0;
            r_rise_en   <= '0;
            r_fall_en   <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;

            if (w_wr_prd || w_tick) r_presc <= '0;
            else                    r_presc <= r_presc + PW'(1);

            // New events are OR-ed in after the clear so a coincident set wins.
            r_rise_pend <= (r_rise_pend & ~w_clr_rise) | w_rise;
            r_fall_pend <= (r_fall_pend & ~w_clr_fall) | w_fall;

            if (w_wr && w_sel == 3'd4) r_rise_en <= bus.wr_data[W-1:0];
            if (w_wr && w_sel == 3'd5) r_fall_en <= bus.wr_data[W-1:0];
            if (w_wr_prd)              r_period  <= bus.wr_data[PW-1:0];

            r_irq <= |((r_rise_pend & r_rise_en) | (r_fall_pend & r_fall_en));
        end
    end

    assign irq = r_irq;

    always_comb begin
        w_rd = '0;
        case (w_sel)
            3'd0: w_rd[W-1:0]  = r_sync2;
            3'd1: w_rd[W-1:0]  = w_level;
            3'd2: w_rd[W-1:0]  = r_rise_pend;
            3'd3: w_rd[W-1:0]  = r_fall_pend;
            3'd4: w_rd[W-1:0]  = r_rise_en;
            3'd5: w_rd[W-1:0]  = r_fall_en;
            3'd6: w_rd[PW-1:0] = r_period;
            default: w_rd = '0;
        endcase
    end

    assign bus.rd_data = w_rd;
endmodule

// File: tb/tb_debounce_event_core.sv
// Directed bench for debounce_event_core: stimulus queues expectations, a negedge
// monitor pops and compares whenever a read or irq sample is presented.
module tb_debounce_event_core;
    localparam int          W       = 8;
    localparam int          PW      = 24;
    localparam logic [31:0] DEF_PRD = 32'd999_999;
    localparam int          THRESH  = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         irq;
    logic         chk_irq = 1'b0;

    debounce_event_if bus();

    debounce_event_core #(.W(W), .PW(PW), .DEF_PRD(DEF_PRD), .THRESH(THRESH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .din   (din),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            if ((bus.cs && bus.read) || chk_irq) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: output presented with no expectation queued");
                end else begin
                    e   = sbq.pop_front();
                    act = e.is_irq ? {31'b0, irq} : bus.rd_data;
                    if (act !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h", e.tag, act, e.exp);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string t);
        exp_t x;
        x.is_irq = 1'b0;
        x.exp    = e;
        x.tag    = t;
        sbq.push_back(x);
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
        idle(1);
        bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
        idle(1);
        bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic ck_irq(input logic e, input string t);
        exp_t x;
        x.is_irq = 1'b1;
        x.exp    = {31'b0, e};
        x.tag    = t;
        sbq.push_back(x);
        chk_irq = 1'b1;
        idle(1);
        chk_irq = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.wr_data = '0;
        idle(3);
        reset = 1'b0;

        // Reset values and address decode
        for (int a = 0; a < 6; a++) rd(5'(a), 32'h0, "reset_reg");
        rd(5'd6, DEF_PRD, "reset_period");
        rd(5'd7, 32'h0, "addr7_zero");
        rd(5'b01110, DEF_PRD, "addr_hi_ignored");
        ck_irq(1'b0, "reset_irq");
        wr(5'd7, 32'hFFFF_FFFF);
        wr(5'd0, 32'hFF);
        wr(5'd1, 32'hFF);
        rd(5'd0, 32'h0, "ro_write_a0");
        rd(5'd1, 32'h0, "ro_write_a1");
        rd(5'd7, 32'h0, "ro_write_a7");

        // period=3: sync latency, then flip on 4th tick (edges +4,+8,+12,+16)
        wr(5'd6, 32'd3);
        din[0] = 1'b1;
        rd(5'd0, 32'h0, "sync_lat1");
        rd(5'd0, 32'h0, "sync_lat2");
        rd(5'd0, 32'h1, "sync_seen");
        idle(12);
        rd(5'd1, 32'h0, "level_before_flip");
        rd(5'd1, 32'h1, "level_at_flip");
        rd(5'd2, 32'h1, "rise_pend_set");
        ck_irq(1'b0, "irq_masked");
        wr(5'd4, 32'h1);
        ck_irq(1'b0, "irq_en_lat");
        ck_irq(1'b1, "irq_en_asserted");

        // W1C all, irq falls one clock later
        wr(5'd2, 32'hFF);
        ck_irq(1'b1, "irq_clr_lat");
        ck_irq(1'b0, "irq_clr_dropped");
        rd(5'd2, 32'h0, "rise_pend_cleared");

        // Bounce ch1 every 5 clk for 40 clk, then hold high
        for (int s = 0; s < 8; s++) begin
            din[1] = (s % 2 == 0);
            rd(5'd1, 32'h1, "bounce_level");
            rd(5'd2, 32'h0, "bounce_no_event");
            idle(3);
        end
        din[1] = 1'b1;
        idle(30);
        rd(5'd1, 32'h3, "bounce_settled");
        rd(5'd2, 32'h2, "bounce_one_rise");
        rd(5'd3, 32'h0, "bounce_no_fall");
        ck_irq(1'b0, "irq_ch1_masked");

        // Fall on ch0 with fall_en
        din[0] = 1'b0;
        idle(30);
        rd(5'd3, 32'h1, "fall_pend_set");
        rd(5'd1, 32'h2, "fall_level");
        wr(5'd5, 32'h1);
        ck_irq(1'b0, "irq_fall_lat");
        ck_irq(1'b1, "irq_fall_asserted");

        // period=0: tick every clock, flip 6 clocks after din change
        wr(5'd6, 32'd0);
        wr(5'd2, 32'hFF);
        wr(5'd3, 32'hFF);
        din[0] = 1'b1;
        idle(10);
        rd(5'd2, 32'h1, "p0_rise");
        din[0] = 1'b0;
        idle(10);
        rd(5'd3, 32'h1, "p0_fall");
        din[0] = 1'b1;
        idle(5);
        wr(5'd2, 32'h1);
        rd(5'd2, 32'h1, "set_wins_clear");
        rd(5'd1, 32'h3, "set_wins_level");
        wr(5'd2, 32'h1);
        rd(5'd2, 32'h0, "w1c_after_set");

        // Reset mid-count with pending events
        din = '0;
        idle(10);
        rd(5'd3, 32'h3, "pend_before_reset");
        ck_irq(1'b1, "irq_before_reset");
        din[0] = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(1);
        for (int a = 0; a < 6; a++) rd(5'(a), 32'h0, "mid_reset_reg");
        rd(5'd6, DEF_PRD, "mid_reset_period");
        ck_irq(1'b0, "mid_reset_irq");
        reset = 1'b0;
        wr(5'd6, 32'd0);
        idle(4);
        rd(5'd1, 32'h0, "restart_before_flip");
        rd(5'd1, 32'h1, "restart_flip");
        rd(5'd2, 32'h1, "restart_rise");

        for (int k = 0; k < 10 && sbq.size() != 0; k++) idle(1);
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
